glitch_free_clock_gate: RTL and testbench
=========================================

GLITCH_FREE_CLOCK_GATE -- requirements
Module: glitch_free_clock_gate

Interface
REQ-001 The block SHALL have exactly one clock and its reset SHALL be synchronous and active-low.
REQ-002 Port clk, input, 1 bit, the only clock: source clock to be gated.
REQ-003 Port reset, input, 1 bit, synchronous, active-low: reset=0 asserts reset.
REQ-004 Port en, input, 1 bit: request to pass clk through to gclk.
REQ-005 Port interlock_n, input, 1 bit: permit from a peer gate (its en_qn); 1 = peer idle.
REQ-006 Port gclk, output, 1 bit: gated clock, equal to clk AND en_q.
REQ-007 Port en_q, output, 1 bit: stage-2 enable state; high while gclk is live.
REQ-008 Port en_qn, output, 1 bit: always the complement of en_q; used as a peer's interlock_n.
REQ-009 Port stage1_q, output, 1 bit: stage-1 enable flop state, for observation.

Function
REQ-010 Stage-1 flop SHALL capture d1 on the rising edge of clk; d1 = en AND interlock_n when the interlock is compiled in (REQ-021), else d1 = en.
REQ-011 Stage-2 flop SHALL capture stage1_q on the falling edge of clk and drive en_q; en_qn = NOT en_q.
REQ-012 gclk SHALL be produced by a single preserved 2-input AND cell (en_q, clk), never merged or re-mapped by synthesis.
REQ-013 en_q SHALL change only while clk is low, so gclk never has a runt high or low pulse.
REQ-014 Enable latency: en=1 set up before rising edge N -> stage1_q=1 after edge N, en_q=1 at the next falling edge, first gclk high pulse at rising edge N+1.
REQ-015 Disable latency: en=0 set up before rising edge N -> the gclk high phase starting at edge N is still full width; en_q=0 at the next falling edge; no gclk pulse from edge N+1.
REQ-016 A 1-cycle en pulse (high for exactly one sampling edge) SHALL yield exactly one full gclk pulse.
REQ-017 While en_q=0, gclk SHALL be constant 0 regardless of clk.
REQ-018 With the interlock compiled in and interlock_n=0, stage1_q SHALL be 0 at the next rising edge regardless of en.

Reset
REQ-019 Stage 1 SHALL load 0 on a rising edge with reset=0, and stage 2 SHALL load 0 on a falling edge with reset=0. There is no asynchronous path.
REQ-020 Reset values: stage1_q=0, en_q=0, en_qn=1, gclk=0 after the first falling edge under reset. Reset asserted mid-operation stops gclk after the current high phase without truncating it.

Configuration
REQ-021 With macro GCG_INTERLOCK_EN defined, d1 SHALL be en AND interlock_n. Without it, d1 SHALL be en, and interlock_n SHALL be present but ignored.

Structure
REQ-022 Package gcg_pkg SHALL hold the reset-active-level constant (RST_ACTIVE = 1'b0) and the stage-reset-value constant (1'b0).
REQ-023 The preserved AND SHALL be a sub-module gcg_keep_and2 (ports A, B, X) carrying a keep/dont-touch attribute. Both flops SHALL be written inline in glitch_free_clock_gate.

Verification
REQ-024 Reset: reset=0 for 3 clk cycles with en=1 -> stage1_q=0, en_q=0, en_qn=1, gclk=0 throughout.
REQ-025 Enable: release reset, en=1 before rising edge 5 -> en_q rises at falling edge 5, gclk pulses start at edge 6, each pulse equal to the clk high width.
REQ-026 Disable: en=0 before rising edge 10 -> full gclk pulse at edge 10, en_q=0 at falling edge 10, gclk=0 from edge 11 on.
REQ-027 Pulse: en high for exactly one sampling edge -> exactly 1 gclk pulse, counted.
REQ-028 Interlock (GCG_INTERLOCK_EN): en=1 with interlock_n=0 -> gclk stays 0. Then interlock_n=1 before edge N -> first gclk pulse at edge N+1.
REQ-029 Glitch check: toggle en at random times inside the clk high phase for 1000 cycles -> no gclk pulse is shorter than the clk high time, and en_qn = NOT en_q always.

Source files
------------

// File: rtl/gcg_pkg.sv
`timescale 1ns/1ps
// Shared constants for the glitch-free clock gate.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: none.
//
// Contents:
//   RST_ACTIVE    - level of the synchronous reset input that asserts reset (active-low).
//   STAGE_RST_VAL - value both enable stages load while reset is asserted.
//   gcg_stage1_d  - stage-1 next-state function, with or without the peer interlock.
package gcg_pkg;

  localparam logic RST_ACTIVE    = 1'b0;
  localparam logic STAGE_RST_VAL = 1'b0;

  // Stage-1 data input. When the interlock is in use, a busy peer
  // (interlock_n = 0) blocks this gate from enabling.
  function automatic logic gcg_stage1_d(input logic en,
                                        input logic interlock_n,
                                        input logic use_interlock);
    logic d;
    d = use_interlock ? (en & interlock_n) : en;
    return d;
  endfunction

endpackage

// File: rtl/gcg_keep_and2.sv
`timescale 1ns/1ps
// Preserved 2-input AND cell forming the gated clock.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   A - enable (stage-2 state, only changes while the clock is low)
//   B - source clock
//   X - gated clock
//
// The keep/dont-touch attributes stop synthesis from merging this gate into
// surrounding logic or re-mapping it into a structure that could glitch.
(* keep = "true", dont_touch = "true" *)
module gcg_keep_and2 (
  input  logic A,
  input  logic B,
  output logic X
);

  (* keep = "true", dont_touch = "true" *)
  logic and_out;

  assign and_out = A & B;
  assign X       = and_out;

endmodule

// File: rtl/glitch_free_clock_gate.sv
`timescale 1ns/1ps
// Glitch-free clock gate: rise-edge request flop, fall-edge enable flop, preserved AND.
// Latency: en sampled at rising edge N -> en_q changes at falling edge N -> gclk from edge N+1.
// Backpressure: none; optional peer interlock (interlock_n) holds off enabling.
//
// Configuration macro: GCG_INTERLOCK_EN (defined -> stage-1 input is en & interlock_n;
//                      undefined -> stage-1 input is en and interlock_n is ignored).
//
// Ports:
//   clk         - source clock (the only clock)
//   reset       - synchronous reset, active-low, sampled on both clock edges by the two stages
//   en          - request to pass clk through to gclk
//   interlock_n - permit from a peer gate's en_qn (1 = peer idle)
//   gclk        - gated clock = clk & en_q
//   en_q        - stage-2 enable state, high while gclk is live
//   en_qn       - complement of en_q, for a peer's interlock_n
//   stage1_q    - stage-1 flop state, for observation
module glitch_free_clock_gate
  import gcg_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic interlock_n,
  output logic gclk,
  output logic en_q,
  output logic en_qn,
  output logic stage1_q
);

`ifdef GCG_INTERLOCK_EN
  localparam logic USE_INTERLOCK = 1'b1;
`else
  localparam logic USE_INTERLOCK = 1'b0;
`endif

  logic d1;

  assign d1 = gcg_stage1_d(en, interlock_n, USE_INTERLOCK);

  // Stage 1: request captured on the rising edge.
  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) begin
      stage1_q <= STAGE_RST_VAL;
    end else begin
      stage1_q <= d1;
    end
  end

  // Stage 2: re-timed onto the falling edge so en_q only moves while clk is
  // low. The AND below therefore never sees its enable change during a high
  // phase, which is what keeps gclk free of runt pulses. A reset asserted
  // mid-operation lands here too, so the current high phase completes.
  always_ff @(negedge clk) begin
    if (reset == RST_ACTIVE) begin
      en_q <= STAGE_RST_VAL;
    end else begin
      en_q <= stage1_q;
    end
  end

  assign en_qn = ~en_q;

  gcg_keep_and2 u_gate_and (
    .A (en_q),
    .B (clk),
    .X (gclk)
  );

endmodule

// File: tb/tb_glitch_free_clock_gate.sv
`timescale 1ns/1ps
module tb_glitch_free_clock_gate;

  localparam int HALF = 5;

`ifdef GCG_INTERLOCK_EN
  localparam bit IL_ON = 1'b1;
`else
  localparam bit IL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, en, interlock_n;
  logic gclk, en_q, en_qn, stage1_q;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  glitch_free_clock_gate dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .interlock_n (interlock_n),
    .gclk        (gclk),
    .en_q        (en_q),
    .en_qn       (en_qn),
    .stage1_q    (stage1_q)
  );

  always #HALF clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  // Pulse counter and pulse-width monitor: every gclk high pulse must last
  // exactly one clk high phase.
  time rise_t;
  bit  have_rise = 1'b0;
  always @(gclk) begin
    if (gclk === 1'b1) begin
      rise_t    = $time;
      have_rise = 1'b1;
      pulse_cnt++;
    end else if (gclk === 1'b0 && have_rise) begin
      have_rise = 1'b0;
      n_checks++;
      if (($time - rise_t) == HALF) n_pass++;
      else $display("FAIL gclk_width: got %0t expected %0d at %0t", $time - rise_t, HALF, $time);
    end
  end

  typedef struct {
    logic rst;
    logic en;
    logic il_n;
    logic exp_s1;   // stage1_q after this rising edge
    logic exp_g;    // gclk during the high phase starting at this edge
    logic exp_q;    // en_q after the following falling edge
  } row_t;

  // Called just after a falling edge; applies one row for one full cycle.
  task automatic apply_row(input row_t r, input string tag);
    reset       = r.rst;
    en          = r.en;
    interlock_n = r.il_n;
    @(posedge clk); #1;
    check({tag, ".stage1_q"}, stage1_q, r.exp_s1);
    check({tag, ".gclk_hi_early"}, gclk, r.exp_g);
    #(HALF - 2);
    check({tag, ".gclk_hi_late"}, gclk, r.exp_g);
    @(negedge clk); #1;
    check({tag, ".en_q"}, en_q, r.exp_q);
    check({tag, ".en_qn"}, en_qn, ~r.exp_q);
    check({tag, ".gclk_lo"}, gclk, 1'b0);
  endtask

  row_t tbl[19];
  row_t seq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev_d1, cur_d1;
    int   exp_pulses;

    //          rst  en  il  s1  g   q
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0}; // reset held with en=1
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0}; // release, idle
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1}; // enable sampled
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1}; // first pulse
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0}; // disable: this pulse still full
    tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0}; // no pulse
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1}; // single-cycle en
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1};
    tbl[13] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
    tbl[14] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0}; // reset mid-op: pulse not truncated
    tbl[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1};
    tbl[17] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
    tbl[18] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};

    reset = 1'b0; en = 1'b1; interlock_n = 1'b1;
    // Warm-up cycle: en_q is unknown until the first falling edge under reset.
    @(negedge clk); #1;

    foreach (tbl[i]) apply_row(tbl[i], $sformatf("tbl%0d", i));

    // One-cycle en pulse yields exactly one gclk pulse.
    pulse_cnt = 0;
    seq.delete();
    seq.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1});
    seq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0});
    seq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0});
    seq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0});
    foreach (seq[i]) apply_row(seq[i], $sformatf("pulse%0d", i));
    n_checks++;
    if (pulse_cnt == 1) n_pass++;
    else $display("FAIL pulse_count: got %0d expected 1", pulse_cnt);

    // Interlock: busy peer blocks enabling (only when compiled in).
    seq.delete();
    if (IL_ON) begin
      seq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0});
      seq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0});
      seq.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1}); // permit before edge N
      seq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0}); // first pulse at N+1
    end else begin
      seq.push_back('{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1}); // interlock_n ignored
      seq.push_back('{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1});
      seq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0});
      seq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0});
    end
    seq.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0});
    foreach (seq[i]) apply_row(seq[i], $sformatf("ilock%0d", i));

    // Random en toggling inside the clk high phase, against a model that
    // says: gclk is high during the phase after edge k iff the request
    // sampled at edge k-1 was granted.
    pulse_cnt  = 0;
    exp_pulses = 0;
    prev_d1    = 1'b0;
    en          = 1'($urandom_range(0, 1));
    interlock_n = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk);
      cur_d1 = en & (IL_ON ? interlock_n : 1'b1);
      #1;
      check("rnd.gclk", gclk, prev_d1);
      check("rnd.en_q", en_q, prev_d1);
      check("rnd.en_qn", en_qn, ~prev_d1);
      if (prev_d1) exp_pulses++;
      prev_d1 = cur_d1;
      #($urandom_range(1, HALF - 2));
      en          = 1'($urandom_range(0, 1));
      interlock_n = 1'($urandom_range(0, 1));
    end
    @(negedge clk); #1;
    n_checks++;
    if (pulse_cnt == exp_pulses) n_pass++;
    else $display("FAIL rnd.pulse_count: got %0d expected %0d", pulse_cnt, exp_pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
